gcd_controller: RTL
===================

Name: gcd_controller

Overview:
- FSM that sequences the GCD datapath (repeated subtraction): loads operand A, then operand B, then issues one subtract-and-load per cycle until the comparator reports equality.
- Consumes comparator flags gt/lt/eq (A vs B) from the datapath; drives ldA, ldB, sel1, sel2, sel_in back to it.
- Provides start/ready/busy/done handshake to the host, a subtraction counter, and an iteration-cap error for degenerate operands (e.g. B=0), which otherwise never converge.

Parameters:
- ITER_W, 16, width of subtraction counter iter_cnt.
- MAX_ITER, 65535, subtraction cap; must be < 2**ITER_W; error when reached without eq.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; honoured only in IDLE.
- gt  input  1  datapath: A > B.
- lt  input  1  datapath: A < B.
- eq  input  1  datapath: A == B.
- ldA  output  1  load register A from bus.
- ldB  output  1  load register B from bus.
- sel1  output  1  subtractor minuend mux: 0=A, 1=B.
- sel2  output  1  subtractor subtrahend mux: 0=A, 1=B.
- sel_in  output  1  bus mux: 0=subtractor result, 1=data_in.
- ready  output  1  high in IDLE.
- busy  output  1  high in LOAD_A, LOAD_B, COMPUTE.
- done  output  1  one-cycle pulse; result valid in datapath register A (and B).
- err  output  1  one-cycle pulse; iteration cap hit.
- iter_cnt  output  ITER_W  subtractions performed in current/last run; held until next start.

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, DONE, ERR. Registered state; outputs decoded from state (COMPUTE also from flags).
- Reset (rst_n=0 at clk edge): state=IDLE, iter_cnt=0; all control outputs 0, ready=1, busy=done=err=0. Reset mid-run aborts immediately; datapath registers are not touched.
- IDLE: ready=1. start=1 -> LOAD_A, iter_cnt cleared to 0. start outside IDLE ignored (no restart, no queueing).
- LOAD_A: ldA=1, sel_in=1. Host holds operand A on data_in this cycle. -> LOAD_B.
- LOAD_B: ldB=1, sel_in=1. Host holds operand B on data_in this cycle. -> COMPUTE.
- COMPUTE, flag priority eq > gt > lt:
  - eq=1: no load -> DONE.
  - else if iter_cnt == MAX_ITER: no load -> ERR.
  - else if gt=1: ldA=1, sel1=0, sel2=1, sel_in=0 (A <= A-B); iter_cnt+1; stay in COMPUTE.
  - else if lt=1: ldB=1, sel1=1, sel2=0, sel_in=0 (B <= B-A); iter_cnt+1; stay in COMPUTE.
  - no flag set (illegal): no load, no increment; stay in COMPUTE (cap does not advance).
- Flags reflect register contents after the previous edge: exactly one subtraction per COMPUTE cycle, no bubble cycles.
- DONE: done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE.
- Unused controls are 0 in every state: sel1, sel2 and sel_in are 0 unless stated; ldA and ldB are never both 1.
- iter_cnt never wraps: the cap check precedes the increment.
- Latency from start at edge T: DONE state (done=1) in cycle T+4+N, where N = subtraction count.

Test Plan:
- A=12, B=8, start at T -> T+3 A<=4, T+4 B<=4, T+5 eq, done=1 at T+6; A=B=4, iter_cnt=2.
- A=7, B=7 -> eq at T+3, no ldA/ldB in COMPUTE, done at T+4, iter_cnt=0.
- A=1, B=16 -> 15 consecutive ldB cycles with sel1=1, sel2=0; done at T+19; B=1, iter_cnt=15.
- MAX_ITER=16, A=5, B=0 -> 16 ldA cycles (A stays 5); err=1 at T+20 with done never asserted; iter_cnt=16, then ready=1.
- start pulses during busy at T+2 and T+4 (A=12, B=8) -> ignored; identical trace to the first scenario, single done.
- rst_n=0 at T+4 mid-COMPUTE -> next cycle IDLE, ldA=ldB=0, iter_cnt=0, ready=1; a fresh start runs correctly.

Source files
------------

// File: rtl/gcd_controller.sv
// Control FSM for a subtract-based GCD datapath: loads A then B, then issues one
// subtract-and-load per cycle until eq, with an iteration cap for operands that never converge.
module gcd_controller #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DONE, ERR} state_t;

  localparam logic [ITER_W-1:0] CAP = ITER_W'(MAX_ITER);

  state_t state, nxt;
  logic   cnt_clr, cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      state <= nxt;
      if (cnt_clr)      iter_cnt <= '0;
      else if (cnt_inc) iter_cnt <= iter_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt     = state;
    ldA     = 1'b0;
    ldB     = 1'b0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    sel_in  = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          nxt     = LOAD_A;
          cnt_clr = 1'b1;
        end
      end
      LOAD_A: begin
        busy   = 1'b1;
        ldA    = 1'b1;
        sel_in = 1'b1;
        nxt    = LOAD_B;
      end
      LOAD_B: begin
        busy   = 1'b1;
        ldB    = 1'b1;
        sel_in = 1'b1;
        nxt    = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        // Cap check sits ahead of the subtract so the counter can never wrap.
        if (eq)                   nxt = DONE;
        else if (iter_cnt == CAP) nxt = ERR;
        else if (gt) begin
          ldA     = 1'b1;
          sel2    = 1'b1;
          cnt_inc = 1'b1;
        end else if (lt) begin
          ldB     = 1'b1;
          sel1    = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      ERR: begin
        err = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
